// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller: captures rising edges into a pending register, masks them,
// and presents the lowest-index enabled source as a held level request with a forced low gap.
module irq_ctrl #(
    parameter int              NSRC     = 8,
    parameter int              W_ID     = $clog2(NSRC),
    parameter int              GAP_CYC  = 1,
    parameter logic [NSRC-1:0] MASK_RST = '1
) (
    input  logic            clk_i,
    input  logic            n_rst_i,
    input  logic [NSRC-1:0] src_i,
    input  logic            cfg_we_i,
    input  logic [NSRC-1:0] cfg_mask_i,
    input  logic            cfg_clr_ovr_i,
    input  logic            halt_i,
    input  logic            ack_i,
    output logic            irq_o,
    output logic [W_ID-1:0] irq_id_o,
    output logic [NSRC-1:0] mask_o,
    output logic [NSRC-1:0] pend_o,
    output logic [NSRC-1:0] ovr_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ASSERT = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;

    logic [NSRC-1:0] src_q, src_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] ovr_q, ovr_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [1:0]      state_q, state_d;
    logic            irq_q, irq_d;
    logic [W_ID-1:0] id_q, id_d;
    logic [3:0]      gap_q, gap_d;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] sel;
    logic [NSRC-1:0] ack_clr;
    logic [NSRC-1:0] new_ovr;
    logic [W_ID-1:0] win_id;
    logic            ack_fire;
    logic            decide;

    assign ack_fire = (state_q == S_ASSERT) && ack_i;

    // Set wins over the ack clear, and a same-cycle re-edge on the acked source is not an overrun.
    always_comb begin : edge_pend
        // NOTE: every combinational output gets a default first so no latch is inferred.
        rise             = src_i & ~src_q;
        ack_clr          = '0;
        if (ack_fire) begin
            ack_clr[id_q] = 1'b1;
        end
        new_ovr = rise & pend_q & ~ack_clr;
        src_d   = src_i;
        pend_d  = (pend_q & ~ack_clr) | rise;
        ovr_d   = cfg_clr_ovr_i ? new_ovr : (ovr_q | new_ovr);
        mask_d  = cfg_we_i ? cfg_mask_i : mask_q;
    end

    always_comb begin : prio
        sel    = pend_q & mask_q;
        win_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (sel[i]) begin
                win_id = W_ID'(i);
            end
        end
    end

    // The last gap cycle doubles as the IDLE decision so re-assertion lands right after the gap.
    always_comb begin : fsm
        state_d = state_q;
        irq_d   = irq_q;
        id_d    = id_q;
        gap_d   = gap_q;
        decide  = 1'b0;
        case (state_q)
            S_IDLE: decide = 1'b1;
            S_ASSERT: begin
                if (ack_i) begin
                    irq_d   = 1'b0;
                    gap_d   = 4'(GAP_CYC);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q <= 4'd1) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                    decide  = 1'b1;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (decide && (sel != '0) && !halt_i) begin
            irq_d   = 1'b1;
            id_d    = win_id;
            state_d = S_ASSERT;
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            src_q   <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
            mask_q  <= MASK_RST;
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
            id_q    <= '0;
            gap_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            src_q   <= src_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            mask_q  <= mask_d;
            state_q <= state_d;
            irq_q   <= irq_d;
            id_q    <= id_d;
            gap_q   <= gap_d;
        end
    end

    assign irq_o    = irq_q;
    assign irq_id_o = id_q;
    assign mask_o   = mask_q;
    assign pend_o   = pend_q;
    assign ovr_o    = ovr_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with fixed expectations, then random traffic against a
// cycle-count reference model of the pending/overrun/request rules.
module tb_irq_ctrl;

    localparam int NSRC    = 8;
    localparam int W_ID    = 3;
    localparam int GAP_CYC = 1;

    logic            clk_i = 1'b0;
    logic            n_rst_i;
    logic [NSRC-1:0] src_i;
    logic            cfg_we_i;
    logic [NSRC-1:0] cfg_mask_i;
    logic            cfg_clr_ovr_i;
    logic            halt_i;
    logic            ack_i;
    logic            irq_o;
    logic [W_ID-1:0] irq_id_o;
    logic [NSRC-1:0] mask_o;
    logic [NSRC-1:0] pend_o;
    logic [NSRC-1:0] ovr_o;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.NSRC(NSRC), .W_ID(W_ID), .GAP_CYC(GAP_CYC), .MASK_RST('1)) dut (
        .clk_i         (clk_i),
        .n_rst_i       (n_rst_i),
        .src_i         (src_i),
        .cfg_we_i      (cfg_we_i),
        .cfg_mask_i    (cfg_mask_i),
        .cfg_clr_ovr_i (cfg_clr_ovr_i),
        .halt_i        (halt_i),
        .ack_i         (ack_i),
        .irq_o         (irq_o),
        .irq_id_o      (irq_id_o),
        .mask_o        (mask_o),
        .pend_o        (pend_o),
        .ovr_o         (ovr_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state: a request is either outstanding or not, and after each ack
    // a number of cycles must pass before the next decision may be made.
    logic            m_req;
    logic [W_ID-1:0] m_id;
    int              m_block;
    logic [NSRC-1:0] m_pend, m_ovr, m_mask, m_src_prev;

    function automatic logic [W_ID-1:0] lowest(input logic [NSRC-1:0] v);
        for (int i = 0; i < NSRC; i++) begin
            if (v[i]) return W_ID'(i);
        end
        return '0;
    endfunction

    task automatic model_reset();
        m_req      = 1'b0;
        m_id       = '0;
        m_block    = 0;
        m_pend     = '0;
        m_ovr      = '0;
        m_mask     = '1;
        m_src_prev = '0;
    endtask

    task automatic model_step();
        logic [NSRC-1:0] edges, clr, novr, sel;
        edges = src_i & ~m_src_prev;
        clr   = '0;
        if (m_req && ack_i) clr[m_id] = 1'b1;
        novr = edges & m_pend & ~clr;
        sel  = m_pend & m_mask;
        if (!m_req) begin
            if (m_block > 0) m_block--;
            else if (sel != '0 && !halt_i) begin
                m_req = 1'b1;
                m_id  = lowest(sel);
            end
        end else if (ack_i) begin
            m_req   = 1'b0;
            m_block = GAP_CYC - 1;
        end
        m_pend     = (m_pend & ~clr) | edges;
        m_ovr      = cfg_clr_ovr_i ? novr : (m_ovr | novr);
        if (cfg_we_i) m_mask = cfg_mask_i;
        m_src_prev = src_i;
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        if (!n_rst_i) model_reset();
        else model_step();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq_o); end
        checks++; if (irq_id_o !== 3'd0) begin errors++; $display("FAIL reset_id got %0d want 0", irq_id_o); end
        checks++; if (pend_o !== 8'h00) begin errors++; $display("FAIL reset_pend got %h want 00", pend_o); end
        checks++; if (ovr_o !== 8'h00) begin errors++; $display("FAIL reset_ovr got %h want 00", ovr_o); end
        checks++; if (mask_o !== 8'hFF) begin errors++; $display("FAIL reset_mask got %h want ff", mask_o); end
        n_rst_i = 1'b1;
        tick();
    endtask

    task automatic test_single_source();
        src_i = 8'h08;
        tick();
        src_i = 8'h00;
        checks++; if (pend_o !== 8'h08) begin errors++; $display("FAIL single_pend got %h want 08", pend_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL single_irq_early got %b want 0", irq_o); end
        tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 3'd3) begin errors++; $display("FAIL single_assert got irq=%b id=%0d want irq=1 id=3", irq_o, irq_id_o); end
        repeat (2) tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 3'd3) begin errors++; $display("FAIL single_hold got irq=%b id=%0d want irq=1 id=3", irq_o, irq_id_o); end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        checks++; if (irq_o !== 1'b0 || pend_o !== 8'h00) begin errors++; $display("FAIL single_ack got irq=%b pend=%h want irq=0 pend=00", irq_o, pend_o); end
        repeat (2) tick();
    endtask

    task automatic test_priority_gap();
        src_i = 8'h24;
        tick();
        src_i = 8'h00;
        tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 3'd2) begin errors++; $display("FAIL prio_first got irq=%b id=%0d want irq=1 id=2", irq_o, irq_id_o); end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        checks++; if (irq_o !== 1'b0 || pend_o !== 8'h20) begin errors++; $display("FAIL prio_gap got irq=%b pend=%h want irq=0 pend=20", irq_o, pend_o); end
        tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 3'd5) begin errors++; $display("FAIL prio_second got irq=%b id=%0d want irq=1 id=5", irq_o, irq_id_o); end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        repeat (2) tick();
        checks++; if (irq_o !== 1'b0 || pend_o !== 8'h00) begin errors++; $display("FAIL prio_idle got irq=%b pend=%h want irq=0 pend=00", irq_o, pend_o); end
    endtask

    task automatic test_mask();
        cfg_we_i   = 1'b1;
        cfg_mask_i = 8'hFE;
        tick();
        cfg_we_i = 1'b0;
        checks++; if (mask_o !== 8'hFE) begin errors++; $display("FAIL mask_write got %h want fe", mask_o); end
        src_i = 8'h01;
        tick();
        src_i = 8'h00;
        checks++; if (pend_o !== 8'h01) begin errors++; $display("FAIL mask_pend got %h want 01", pend_o); end
        repeat (2) tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL mask_blocked got %b want 0", irq_o); end
        cfg_we_i   = 1'b1;
        cfg_mask_i = 8'hFF;
        tick();
        cfg_we_i = 1'b0;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL mask_enable_early got %b want 0", irq_o); end
        tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 3'd0) begin errors++; $display("FAIL mask_enable got irq=%b id=%0d want irq=1 id=0", irq_o, irq_id_o); end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        tick();
    endtask

    task automatic test_overrun();
        src_i = 8'h10;
        tick();
        src_i = 8'h00;
        tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 3'd4) begin errors++; $display("FAIL ovr_assert got irq=%b id=%0d want irq=1 id=4", irq_o, irq_id_o); end
        src_i = 8'h10;
        tick();
        src_i = 8'h00;
        checks++; if (ovr_o !== 8'h10) begin errors++; $display("FAIL ovr_set got %h want 10", ovr_o); end
        cfg_clr_ovr_i = 1'b1;
        tick();
        cfg_clr_ovr_i = 1'b0;
        checks++; if (ovr_o !== 8'h00) begin errors++; $display("FAIL ovr_clear got %h want 00", ovr_o); end
        // Edge coinciding with the ack: pending survives, no overrun.
        src_i = 8'h10;
        ack_i = 1'b1;
        tick();
        src_i = 8'h00;
        ack_i = 1'b0;
        checks++; if (irq_o !== 1'b0 || pend_o !== 8'h10 || ovr_o !== 8'h00) begin errors++; $display("FAIL ovr_setwins got irq=%b pend=%h ovr=%h want irq=0 pend=10 ovr=00", irq_o, pend_o, ovr_o); end
        tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 3'd4) begin errors++; $display("FAIL ovr_reassert got irq=%b id=%0d want irq=1 id=4", irq_o, irq_id_o); end
        // Clear coinciding with a fresh overrun: the overrun wins.
        src_i         = 8'h10;
        cfg_clr_ovr_i = 1'b1;
        tick();
        src_i         = 8'h00;
        cfg_clr_ovr_i = 1'b0;
        checks++; if (ovr_o !== 8'h10) begin errors++; $display("FAIL ovr_clr_race got %h want 10", ovr_o); end
        ack_i = 1'b1;
        tick();
        ack_i         = 1'b0;
        cfg_clr_ovr_i = 1'b1;
        tick();
        cfg_clr_ovr_i = 1'b0;
        checks++; if (ovr_o !== 8'h00 || pend_o !== 8'h00) begin errors++; $display("FAIL ovr_final got ovr=%h pend=%h want ovr=00 pend=00", ovr_o, pend_o); end
        tick();
    endtask

    task automatic test_halt();
        halt_i = 1'b1;
        src_i  = 8'h02;
        tick();
        src_i = 8'h00;
        repeat (2) tick();
        checks++; if (irq_o !== 1'b0 || pend_o !== 8'h02) begin errors++; $display("FAIL halt_block got irq=%b pend=%h want irq=0 pend=02", irq_o, pend_o); end
        halt_i = 1'b0;
        tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 3'd1) begin errors++; $display("FAIL halt_release got irq=%b id=%0d want irq=1 id=1", irq_o, irq_id_o); end
        halt_i = 1'b1;
        repeat (3) tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 3'd1) begin errors++; $display("FAIL halt_hold got irq=%b id=%0d want irq=1 id=1", irq_o, irq_id_o); end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        checks++; if (irq_o !== 1'b0 || pend_o !== 8'h00) begin errors++; $display("FAIL halt_ack got irq=%b pend=%h want irq=0 pend=00", irq_o, pend_o); end
        halt_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        cfg_we_i   = 1'b1;
        cfg_mask_i = 8'h7F;
        tick();
        cfg_we_i = 1'b0;
        src_i    = 8'h44;
        tick();
        src_i = 8'h00;
        tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 3'd2) begin errors++; $display("FAIL rstmid_pre got irq=%b id=%0d want irq=1 id=2", irq_o, irq_id_o); end
        #2;
        n_rst_i = 1'b0;
        model_reset();
        #1;
        checks++; if (irq_o !== 1'b0 || pend_o !== 8'h00 || mask_o !== 8'hFF) begin errors++; $display("FAIL rstmid got irq=%b pend=%h mask=%h want irq=0 pend=00 mask=ff", irq_o, pend_o, mask_o); end
        @(posedge clk_i);
        #1;
        n_rst_i = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            src_i         = NSRC'($urandom & $urandom);
            ack_i         = ($urandom_range(0, 9) < 3);
            halt_i        = ($urandom_range(0, 9) == 0);
            cfg_we_i      = ($urandom_range(0, 19) == 0);
            cfg_mask_i    = NSRC'($urandom | $urandom);
            cfg_clr_ovr_i = ($urandom_range(0, 19) == 0);
            tick();
            checks++; if (irq_o !== m_req) begin errors++; $display("FAIL rnd_irq cyc %0d got %b want %b", c, irq_o, m_req); end
            if (m_req) begin
                checks++; if (irq_id_o !== m_id) begin errors++; $display("FAIL rnd_id cyc %0d got %0d want %0d", c, irq_id_o, m_id); end
            end
            checks++; if (pend_o !== m_pend) begin errors++; $display("FAIL rnd_pend cyc %0d got %h want %h", c, pend_o, m_pend); end
            checks++; if (ovr_o !== m_ovr) begin errors++; $display("FAIL rnd_ovr cyc %0d got %h want %h", c, ovr_o, m_ovr); end
            checks++; if (mask_o !== m_mask) begin errors++; $display("FAIL rnd_mask cyc %0d got %h want %h", c, mask_o, m_mask); end
        end
        src_i         = '0;
        ack_i         = 1'b0;
        halt_i        = 1'b0;
        cfg_we_i      = 1'b0;
        cfg_clr_ovr_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        n_rst_i       = 1'b0;
        src_i         = '0;
        cfg_we_i      = 1'b0;
        cfg_mask_i    = '0;
        cfg_clr_ovr_i = 1'b0;
        halt_i        = 1'b0;
        ack_i         = 1'b0;
        test_reset();
        test_single_source();
        test_priority_gap();
        test_mask();
        test_overrun();
        test_halt();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Multi-source interrupt controller for the pico core. It captures rising edges on up to NSRC synchronous interrupt sources into a pending register and applies a programmable mask. It picks the highest-priority unmasked pending source and presents it to the core's single `ext_int_i` line as a level request with a source ID, held until acknowledged. Between requests it forces a guaranteed low gap, so the core's rising-edge detector sees every request as a distinct edge.

## Interface
- `NSRC`, 8, number of interrupt sources (2..32).
- `W_ID`, `$clog2(NSRC)`, width of the source ID.
- `GAP_CYC`, 1, cycles `irq_o` is held low after an ack before a new request may assert (1..15).
- `MASK_RST`, all ones, reset value of the enable mask (1 = enabled).
- `clk_i`, in, 1, core clock.
- `n_rst_i`, in, 1, reset, asynchronous active-low.
- `src_i`, in, NSRC, interrupt sources, synchronous to `clk_i`.
- `cfg_we_i`, in, 1, mask write strobe.
- `cfg_mask_i`, in, NSRC, new mask value, loaded when `cfg_we_i`=1.
- `cfg_clr_ovr_i`, in, 1, clears all overrun flags.
- `halt_i`, in, 1, core halted; blocks new requests.
- `ack_i`, in, 1, core acknowledge of the current request.
- `irq_o`, out, 1, interrupt request to the core's `ext_int_i`.
- `irq_id_o`, out, W_ID, ID of the requesting source; valid while `irq_o`=1.
- `mask_o`, out, NSRC, current mask.
- `pend_o`, out, NSRC, current pending register.
- `ovr_o`, out, NSRC, sticky overrun flags.

## Operation
- Edge capture:
  - `src_q` holds `src_i` delayed one cycle.
  - The edge term is `src_i & ~src_q`.
  - On an edge, `pend[i]` is set regardless of the mask.
  - An edge while `pend[i]` is already 1 also sets `ovr[i]`.
- Selection: `sel = pend & mask`. Priority is fixed: lowest index wins.
- FSM states are IDLE, ASSERT and GAP.
  - **IDLE:** if `sel`≠0 and `halt_i`=0, latch the winning index into `irq_id_o`, drive `irq_o`=1 and go to ASSERT.
  - **ASSERT:** `irq_o` and `irq_id_o` are held stable. Mask writes and new edges do not change the latched ID. On `ack_i`=1: clear `pend[irq_id_o]`, drive `irq_o`=0, load the gap counter with GAP_CYC, go to GAP.
  - **GAP:** `irq_o`=0. The counter decrements each cycle; at 0 the FSM goes to IDLE.
- `ack_i` is ignored outside ASSERT.
- If `halt_i` rises while in ASSERT, the request is held until acked.
- A source edge in the same cycle as the ack that clears that source's pending bit leaves the bit set: set wins over clear, and `ovr` is not set.
- `cfg_we_i` takes effect the following cycle.
- When `cfg_clr_ovr_i` coincides with a new overrun, the new overrun wins.
- A mask bit of 0 only stops selection; the pending bit is kept and is serviced once the bit is re-enabled.

## Timing
- Reset values: `irq_o`=0, `irq_id_o`=0, `pend`=0, `ovr`=0, `src_q`=0, `mask`=MASK_RST, FSM=IDLE, gap counter=0.
- Because `src_q` resets to 0, a source already high at reset release produces an edge in the first cycle.
- Assertion latency: edge in cycle t (src_i high, src_q low) -> `pend` set in t+1 -> `irq_o`=1 in t+2. Mask and halt are evaluated in cycle t+1.
- Ack latency: `ack_i` in cycle a -> `irq_o`=0 and `pend` bit cleared in a+1.
- Re-assertion: low for cycles a+1 .. a+GAP_CYC. The earliest re-assertion is a+GAP_CYC+1 if `sel`≠0 in cycle a+GAP_CYC.
- All outputs are registered; no combinational path from any input to any output.
- Reset asserted mid-request drops `irq_o` asynchronously; the pending state is lost.

## Test plan
- **Single source:** pulse `src_i[3]` for 1 cycle at t=10 -> `pend_o`=0x08 at 11, `irq_o`=1 with `irq_id_o`=3 at 12. Ack at 15 -> `irq_o`=0 and `pend_o`=0 at 16.
- **Priority and gap:** edges on sources 5 and 2 in the same cycle -> ID 2 served first. After ack at a, `irq_o` is low for exactly GAP_CYC=1 cycle, then reasserts at a+2 with ID 5.
- **Mask:** write mask 0xFE, edge on source 0 -> `pend_o`=0x01 and `irq_o` stays 0. Write mask 0xFF -> `irq_o`=1 with ID 0 two cycles after the write.
- **Overrun and set-wins:**
  - A second edge on source 4 while it is pending -> `ovr_o[4]`=1.
  - An edge on source 4 in the ack cycle -> `pend_o[4]` stays 1 and the request reasserts after the gap.
  - `cfg_clr_ovr_i` -> `ovr_o`=0.
- **Halt:**
  - `halt_i`=1 with a source pending -> no assertion. `halt_i`=0 -> `irq_o`=1 next cycle.
  - `halt_i` rising during ASSERT -> `irq_o` held until ack.
- **Reset mid-request:** `n_rst_i` low while in ASSERT -> `irq_o`=0 immediately, `pend_o`=0, `mask_o`=MASK_RST.
